// File: rtl/apb_timer_sub.sv
// APB subordinate hosting a 32-bit auto-reload up-counter with a prescaler
// and a level interrupt; completion is stretched by WAIT_STATES cycles.
module apb_timer_sub #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned PSC_W       = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        irq
);

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  localparam logic [9:0] W_CTRL   = 10'h000;
  localparam logic [9:0] W_PSC    = 10'h001;
  localparam logic [9:0] W_ARR    = 10'h002;
  localparam logic [9:0] W_CNT    = 10'h003;
  localparam logic [9:0] W_STATUS = 10'h004;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;

  logic [2:0]       ctrl;
  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_cnt;
  logic [31:0]      arr;
  logic [31:0]      cnt;
  logic             uif;

  logic [9:0]  word;
  logic        wr;
  logic        wr_ctrl, wr_psc, wr_arr, wr_cnt, wr_status;
  logic        tick;
  logic        reload;
  logic [31:0] rdata;
  logic        unused_addr_bits;

  assign word             = PADDR[11:2];
  assign unused_addr_bits = ^{PADDR[31:12], PADDR[1:0]};

  // ---------------------------------------------------------------------
  // APB handshake
  // ---------------------------------------------------------------------
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    PREADY       = 1'b0;
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_nxt    = ACCESS;
          wait_cnt_nxt = WS_INIT;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_nxt = IDLE;
        end else if (PENABLE) begin
          if (wait_cnt != '0) begin
            wait_cnt_nxt = wait_cnt - 4'd1;
          end else begin
            PREADY    = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          // a fresh SETUP without a completed access restarts the wait count
          wait_cnt_nxt = WS_INIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr        = PREADY && PWRITE;
  assign wr_ctrl   = wr && (word == W_CTRL);
  assign wr_psc    = wr && (word == W_PSC);
  assign wr_arr    = wr && (word == W_ARR);
  assign wr_cnt    = wr && (word == W_CNT);
  assign wr_status = wr && (word == W_STATUS);

  // ---------------------------------------------------------------------
  // Timer core
  // ---------------------------------------------------------------------
  assign tick   = ctrl[0] && (psc_cnt == psc);
  assign reload = tick && (cnt >= arr);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl <= PWDATA[2:0];
    end else if (reload && ctrl[1]) begin
      ctrl[0] <= 1'b0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      psc <= '0;
    end else if (wr_psc) begin
      psc <= PWDATA[PSC_W-1:0];
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      psc_cnt <= '0;
    end else if (wr_psc || tick) begin
      psc_cnt <= '0;
    end else if (ctrl[0]) begin
      psc_cnt <= psc_cnt + 1'b1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      arr <= '0;
    end else if (wr_arr) begin
      arr <= PWDATA;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt <= '0;
    end else if (wr_cnt) begin
      cnt <= PWDATA;
    end else if (reload) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 32'd1;
    end
  end

  // hardware set takes priority over a same-cycle write-1-to-clear
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      uif <= 1'b0;
    end else if (reload) begin
      uif <= 1'b1;
    end else if (wr_status && PWDATA[0]) begin
      uif <= 1'b0;
    end
  end

  assign irq = uif && ctrl[2];

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    case (word)
      W_CTRL:   rdata = {29'd0, ctrl};
      W_PSC:    rdata = 32'(psc);
      W_ARR:    rdata = arr;
      W_CNT:    rdata = cnt;
      W_STATUS: rdata = {31'd0, uif};
      default:  rdata = '0;
    endcase
  end

  assign PRDATA = (PREADY && !PWRITE) ? rdata : '0;

endmodule

// File: tb/tb_apb_timer_sub.sv
// Bench for apb_timer_sub: cycle-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized APB traffic.
module tb_apb_timer_sub;

  localparam int WS = 1;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        irq_o   [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 PCLK = ~PCLK;

  apb_timer_sub #(.WAIT_STATES(WS), .PSC_W(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(paddr[0]), .PSEL(psel[0]),
    .PENABLE(penable[0]), .PWRITE(pwrite[0]), .PWDATA(pwdata[0]),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .irq(irq_o[0])
  );

  apb_timer_sub #(.WAIT_STATES(0), .PSC_W(16)) dut_zw (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(paddr[1]), .PSEL(psel[1]),
    .PENABLE(penable[1]), .PWRITE(pwrite[1]), .PWDATA(pwdata[1]),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .irq(irq_o[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model of the first instance ----------------
  logic [2:0]  m_ctrl;
  logic [15:0] m_psc, m_pscc;
  logic [31:0] m_arr, m_cnt;
  logic        m_uif;
  logic        m_busy;
  int          m_waited;

  function automatic logic exp_ready();
    return m_busy && psel[0] && penable[0] && (m_waited >= WS);
  endfunction

  function automatic logic [31:0] reg_val(input logic [11:0] off);
    case (off[11:2])
      10'd0:   return {29'd0, m_ctrl};
      10'd1:   return {16'd0, m_psc};
      10'd2:   return m_arr;
      10'd3:   return m_cnt;
      10'd4:   return {31'd0, m_uif};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge PCLK or posedge PRESET) begin : model
    logic       r, wr, tick, reload;
    logic [9:0] o;
    if (PRESET) begin
      m_ctrl <= '0; m_psc <= '0; m_pscc <= '0; m_arr <= '0; m_cnt <= '0;
      m_uif <= 1'b0; m_busy <= 1'b0; m_waited <= 0;
    end else begin
      r      = exp_ready();
      wr     = r && pwrite[0];
      o      = paddr[0][11:2];
      tick   = m_ctrl[0] && (m_pscc == m_psc);
      reload = tick && (m_cnt >= m_arr);
      // prescaler
      if (wr && o == 10'd1) m_pscc <= 16'd0;
      else if (tick)        m_pscc <= 16'd0;
      else if (m_ctrl[0])   m_pscc <= m_pscc + 16'd1;
      if (wr && o == 10'd1) m_psc <= pwdata[0][15:0];
      if (wr && o == 10'd2) m_arr <= pwdata[0];
      // counter: an APB write wins over the timer
      if (wr && o == 10'd3) m_cnt <= pwdata[0];
      else if (tick)        m_cnt <= reload ? 32'd0 : m_cnt + 32'd1;
      if (reload) m_uif <= 1'b1;
      else if (wr && o == 10'd4 && pwdata[0][0]) m_uif <= 1'b0;
      if (wr && o == 10'd0) m_ctrl <= pwdata[0][2:0];
      else if (reload && m_ctrl[1]) m_ctrl <= m_ctrl & 3'b110;
      // transfer tracking: accesses elapsed since the setup phase
      if (!m_busy) begin
        if (psel[0] && !penable[0]) begin m_busy <= 1'b1; m_waited <= 0; end
      end else if (!psel[0]) begin
        m_busy <= 1'b0;
      end else if (penable[0]) begin
        if (r) m_busy <= 1'b0;
        else   m_waited <= m_waited + 1;
      end else begin
        m_waited <= 0;
      end
    end
  end

  always @(negedge PCLK) begin
    chk("pready", 32'(pready[0]), 32'(exp_ready()));
    chk("prdata", prdata[0],
        (exp_ready() && !pwrite[0]) ? reg_val(paddr[0][11:0]) : 32'd0);
    chk("irq", 32'(irq_o[0]), 32'(m_uif && m_ctrl[2]));
  end

  // ---------------- transaction driver ----------------
  // entered and left at 1ns after a rising edge
  task automatic apb(input int which, input logic w, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output int waits);
    bit done = 0;
    rd = '0;
    waits = 0;
    psel[which] = 1'b1; penable[which] = 1'b0; pwrite[which] = w;
    paddr[which] = a; pwdata[which] = d;
    @(posedge PCLK); #1;
    penable[which] = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge PCLK);
      if (pready[which]) begin rd = prdata[which]; done = 1; end
      else waits++;
      @(posedge PCLK); #1;
    end
    if (!done) chk("apb_timeout", 32'(waits), 32'd0);
    psel[which] = 1'b0; penable[which] = 1'b0; pwrite[which] = 1'b0;
  endtask

  task automatic wr0(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd; int w;
    apb(0, 1'b1, a, d, rd, w);
  endtask

  task automatic rd0(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; int w;
    apb(0, 1'b0, a, 32'd0, rd, w);
    chk(nm, rd, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge PCLK); #1; end
  endtask

  initial begin
    logic [31:0] rd, a, d, t0;
    int w, k;
    bit got;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
      paddr[i] = '0; pwdata[i] = '0;
    end
    // reset with a transfer apparently in flight
    PRESET = 1'b1;
    psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 32'h8;
    #7;
    chk("rst_pready", 32'(pready[0]), 32'd0);
    chk("rst_prdata", prdata[0], 32'd0);
    chk("rst_irq", 32'(irq_o[0]), 32'd0);
    #5 psel[0] = 1'b0; penable[0] = 1'b0;
    #10 PRESET = 1'b0;
    @(posedge PCLK); #1;
    rd0("rst_ctrl", 32'h000, 32'd0);
    rd0("rst_psc", 32'h004, 32'd0);
    rd0("rst_arr", 32'h008, 32'd0);
    rd0("rst_cnt", 32'h00C, 32'd0);
    rd0("rst_status", 32'h010, 32'd0);

    // wait-state pattern
    apb(0, 1'b1, 32'h1000_1008, 32'h5, rd, w);
    chk("ws_write", 32'(w), 32'd1);
    apb(0, 1'b0, 32'h1000_1008, 32'h0, rd, w);
    chk("ws_read", 32'(w), 32'd1);
    chk("arr_readback", rd, 32'd5);
    apb(0, 1'b0, 32'h1000_1020, 32'h0, rd, w);
    chk("unmapped_waits", 32'(w), 32'd1);
    chk("unmapped_data", rd, 32'd0);

    // prescaled run with interrupt
    wr0(32'h004, 32'd1);
    wr0(32'h00C, 32'd0);
    wr0(32'h008, 32'd3);
    wr0(32'h000, 32'b101);
    got = 0; k = 0;
    for (int i = 1; i <= 50 && !got; i++) begin
      @(negedge PCLK);
      if (irq_o[0]) begin got = 1; k = i; end
    end
    chk("irq_latency", 32'(k), 32'd9);
    @(posedge PCLK); #1;
    rd0("psc_uif", 32'h010, 32'd1);
    wr0(32'h000, 32'd0);
    wr0(32'h010, 32'd1);
    rd0("uif_cleared", 32'h010, 32'd0);

    // one-shot
    wr0(32'h004, 32'd0);
    wr0(32'h00C, 32'd0);
    wr0(32'h008, 32'd2);
    wr0(32'h000, 32'b011);
    idle(10);
    rd0("oneshot_ctrl", 32'h000, 32'b010);
    rd0("oneshot_cnt", 32'h00C, 32'd0);
    rd0("oneshot_uif", 32'h010, 32'd1);
    wr0(32'h010, 32'd0);
    rd0("w0_no_effect", 32'h010, 32'd1);
    wr0(32'h010, 32'd1);
    rd0("w1c", 32'h010, 32'd0);

    // ARR lowered below a running CNT
    wr0(32'h008, 32'd1000);
    wr0(32'h00C, 32'd10);
    wr0(32'h000, 32'b001);
    wr0(32'h008, 32'd4);
    idle(2);
    rd0("arr_below_uif", 32'h010, 32'd1);
    // ARR = 0 reloads on every tick, so the W1C always collides with a set
    wr0(32'h008, 32'd0);
    wr0(32'h010, 32'd1);
    rd0("w1c_vs_set", 32'h010, 32'd1);
    wr0(32'h000, 32'd0);
    wr0(32'h010, 32'd1);
    rd0("w1c_after_stop", 32'h010, 32'd0);

    // reset during the completing cycle of a write
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 32'h008; pwdata[0] = 32'h77;
    @(posedge PCLK); #1 penable[0] = 1'b1;
    @(posedge PCLK); #1;
    chk("mid_pready_hi", 32'(pready[0]), 32'd1);
    #2 PRESET = 1'b1;
    #1 chk("mid_pready_drop", 32'(pready[0]), 32'd0);
    psel[0] = 1'b0; penable[0] = 1'b0; pwrite[0] = 1'b0;
    @(negedge PCLK); @(negedge PCLK);
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    rd0("mid_not_committed", 32'h008, 32'd0);

    // randomized traffic, checked by the per-cycle model
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(7))
        0: begin a = 32'h000; d = $urandom & 32'h7;  end
        1: begin a = 32'h004; d = $urandom_range(3); end
        2: begin a = 32'h008; d = $urandom_range(19); end
        3: begin a = 32'h00C; d = $urandom_range(23); end
        4: begin a = 32'h010; d = $urandom & 32'h1;  end
        5: begin a = 32'h014; d = $urandom;          end
        6: begin a = 32'h020; d = $urandom;          end
        default: begin a = 32'hFFC; d = $urandom;    end
      endcase
      a = {$urandom_range(32'hFFFFF), a[11:2], 2'($urandom_range(3))};
      apb(0, 1'($urandom_range(1)), a, d, rd, w);
      idle($urandom_range(3));
    end

    // zero-wait instance: back-to-back write then read
    t0 = $time;
    apb(1, 1'b1, 32'h00C, 32'h1234, rd, w);
    chk("zw_write_waits", 32'(w), 32'd0);
    apb(1, 1'b0, 32'h00C, 32'h0, rd, w);
    chk("zw_read_waits", 32'(w), 32'd0);
    chk("zw_readback", rd, 32'h1234);
    chk("zw_duration", 32'($time - t0), 32'd40);
    apb(1, 1'b1, 32'h008, 32'hFFFF, rd, w);
    apb(1, 1'b1, 32'h000, 32'h1, rd, w);
    apb(1, 1'b1, 32'h00C, 32'd100, rd, w);
    apb(1, 1'b0, 32'h00C, 32'h0, rd, w);
    chk("zw_running_read", rd, 32'd101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_timer_sub.md
Name: apb_timer_sub

Overview:
- APB subordinate (responder) hosting a programmable 32-bit up-counter timer with a 16-bit prescaler, auto-reload and an interrupt flag.
- Sits on one PSELx slot of the APB manager, e.g. 0x1000_1xxx. The manager performs address-region decoding; this block decodes only the 4 KiB-offset bits.
- Inserts a configurable number of wait states through PREADY.

Parameters:
- WAIT_STATES, 1, number of ACCESS cycles with PREADY low before completion (0..15).
- PSC_W, 16, prescaler register width.

Ports:
- PCLK  in  1  APB clock.
- PRESET  in  1  reset, asynchronous, active-high.
- PADDR  in  32  address; only [11:2] decoded, [1:0] ignored.
- PSEL  in  1  subordinate select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write, 0=read.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer completion.
- irq  out  1  timer interrupt, level.

Behaviour:
- Reset is PRESET, asynchronous, active-high, on clock PCLK. On reset:
  - all registers = 0, FSM = IDLE, wait_cnt = 0;
  - PREADY = 0, PRDATA = 0, irq = 0.
- Register map (offset = PADDR[11:0]):
  - 0x000 CTRL [2:0] = {IRQ_EN, ONESHOT, EN}, upper bits read 0.
  - 0x004 PSC [PSC_W-1:0].
  - 0x008 ARR [31:0].
  - 0x00C CNT [31:0], read/write.
  - 0x010 STATUS [0] = UIF; write-1-to-clear, writing 0 has no effect.
  - Every other offset reads 32'h0; writes to it are ignored and still complete normally.
- APB FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS when PSEL & !PENABLE (setup phase). wait_cnt is loaded with WAIT_STATES on that transition.
  - In ACCESS with PSEL & PENABLE: if wait_cnt != 0, wait_cnt decrements and PREADY = 0. If wait_cnt == 0, PREADY = 1 (combinational) and the FSM returns to IDLE next cycle.
  - ACCESS with PSEL = 0 (aborted transfer): return to IDLE and commit nothing.
  - PREADY = 0 whenever PSEL = 0 or the FSM is in IDLE.
  - WAIT_STATES = 0 gives a zero-wait transfer: PREADY high in the first ACCESS cycle.
- Write commit:
  - Registers update on the PCLK edge ending the cycle where PSEL & PENABLE & PREADY & PWRITE.
  - No register changes during wait cycles.
- Read data:
  - PRDATA = selected register while PREADY = 1 and PWRITE = 0; otherwise 32'h0.
  - Reads have no side effects.
- Back-to-back transfers: a manager SETUP in the cycle immediately after completion is accepted (IDLE -> ACCESS). There are no dead cycles beyond the APB minimum of 2 cycles per transfer plus WAIT_STATES.
- Timer:
  - While EN = 1: psc_cnt increments each cycle. When psc_cnt == PSC, psc_cnt <= 0 and a tick is generated. PSC = 0 gives a tick every cycle.
  - On tick: if CNT >= ARR, then CNT <= 0, UIF <= 1, and EN <= 0 if ONESHOT = 1. Otherwise CNT <= CNT + 1.
  - The >= comparison guarantees reload when ARR is written below the current CNT; no 32-bit wrap without UIF.
  - EN = 0 freezes CNT and psc_cnt (values held, not cleared).
- Simultaneous events:
  - APB write to CNT in the same cycle as a tick: the written value wins and psc_cnt clears to 0.
  - APB write to PSC clears psc_cnt.
  - W1C of UIF in the same cycle as a hardware UIF set: the set wins, UIF = 1.
  - APB write of CTRL.EN in the same cycle as a one-shot auto-clear: the written value wins.
- irq = UIF & IRQ_EN, registered-free (combinational from flops).
- Reset mid-transfer: the FSM returns to IDLE immediately and PREADY drops to 0 asynchronously. The aborted write is not committed.

Test Plan:
- Reset with PSEL = 1, PENABLE = 1 held -> PREADY = 0, PRDATA = 0, irq = 0 during reset. Reading CTRL/PSC/ARR/CNT/STATUS after release -> all 0.
- WAIT_STATES = 1: write ARR = 32'h0000_0005 -> PREADY low for 1 ACCESS cycle, high on the 2nd. Readback of 0x008 = 5 with the same wait pattern. Read 0x020 -> 0 and completes.
- PSC = 1, ARR = 3, CTRL = 3'b101 -> CNT increments every 2 cycles (0,1,2,3,0). UIF and irq rise on the tick where CNT = 3 reloads to 0.
- ONESHOT: PSC = 0, ARR = 2, CTRL = 3'b011 -> CNT 0,1,2,0, then frozen at 0. EN reads 0 and UIF = 1. Writing STATUS = 1 clears UIF. Writing STATUS = 0 leaves it unchanged.
- While running with CNT = 10, write ARR = 4 -> next tick reloads CNT to 0 and sets UIF. A W1C of STATUS timed on a reload tick -> UIF stays 1.
- Back-to-back write then read to CNT with WAIT_STATES = 0; second transfer SETUP in the cycle right after the first PREADY -> both complete in 2 cycles each. Read returns the written value, or +1 if a tick occurred after the write.
